// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and key map for the matrix keypad emulator.
// Key codes map to {row, col} of a 4x4 keypad laid out 123A/456B/789C/E0FD.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_B,
        HELD,
        REL_B
    } emu_state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [3:0] key_to_rc(input logic [3:0] key);
        logic [3:0] rc;
        unique case (key)
            4'h1: rc = 4'b00_00;
            4'h2: rc = 4'b00_01;
            4'h3: rc = 4'b00_10;
            4'hA: rc = 4'b00_11;
            4'h4: rc = 4'b01_00;
            4'h5: rc = 4'b01_01;
            4'h6: rc = 4'b01_10;
            4'hB: rc = 4'b01_11;
            4'h7: rc = 4'b10_00;
            4'h8: rc = 4'b10_01;
            4'h9: rc = 4'b10_10;
            4'hC: rc = 4'b10_11;
            4'hE: rc = 4'b11_00;
            4'h0: rc = 4'b11_01;
            4'hF: rc = 4'b11_10;
            4'hD: rc = 4'b11_11;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) used to randomise contact.
// Exposes the low bit of the value it will hold after the next enabled step.
module bounce_lfsr
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic next_bit
);

    logic [7:0] value;
    logic [7:0] next_value;

    assign next_value = {1'b0, value[7:1]} ^ (value[0] ? LFSR_TAPS : 8'h00);
    assign next_bit   = next_value[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else if (en) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: one emulated key of a 4x4 matrix keypad, driven by commands.
// Produces active-low row sense from scanner columns, with optional bounce.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_W        = 24,
    parameter int unsigned BOUNCE_CYCLES = 16,
    parameter int unsigned BOUNCE_STEP   = 2,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              cmd_bounce,
    input  logic [3:0]        C,
    output logic [3:0]        R,
    output logic              contact,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int unsigned SW = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;

    localparam logic [BW-1:0] WIN_LAST = BW'(BOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] WIN_PRELAST =
        BW'((BOUNCE_CYCLES > 1) ? BOUNCE_CYCLES - 2 : 0);
    localparam logic [SW-1:0] STEP_LAST = SW'(BOUNCE_STEP - 1);
    localparam logic ENTRY_IS_LAST = (BOUNCE_CYCLES <= 1);

    emu_state_t        state;
    logic [BW-1:0]     win_cnt;
    logic [SW-1:0]     step_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_m1;
    logic [1:0]        row_q;
    logic [1:0]        col_q;
    logic              bounce_q;

    logic       accept;
    logic       in_win;
    logic       win_last;
    logic       next_last;
    logic       step_due;
    logic       hold_last;
    logic       win_entry;
    logic       lfsr_en;
    logic       lfsr_bit;
    logic [3:0] key_rc;
    logic [3:0] row_hit;

    assign key_rc    = key_to_rc(cmd_key);
    assign cmd_ready = (state == IDLE) & ~done & ~reset;
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid & cmd_ready;

    assign in_win    = (state == PRESS_B) | (state == REL_B);
    assign win_last  = (win_cnt == WIN_LAST);
    assign next_last = (win_cnt == WIN_PRELAST);
    assign step_due  = (step_cnt == STEP_LAST);
    assign hold_last = (hold_cnt == hold_m1);

    // The LFSR keeps stepping on the forced last window cycle; only contact is pinned.
    assign win_entry = (accept & cmd_bounce)
                     | ((state == HELD) & hold_last & bounce_q);
    assign lfsr_en   = win_entry | (in_win & ~win_last & step_due);

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (lfsr_en),
        .next_bit (lfsr_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            win_cnt  <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            hold_m1  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            bounce_q <= 1'b0;
            contact  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    contact <= 1'b0;
                    if (accept) begin
                        row_q    <= key_rc[3:2];
                        col_q    <= key_rc[1:0];
                        bounce_q <= cmd_bounce;
                        hold_cnt <= '0;
                        hold_m1  <= (cmd_hold == '0) ? '0 : cmd_hold - 1'b1;
                        win_cnt  <= '0;
                        step_cnt <= '0;
                        if (cmd_bounce) begin
                            state   <= PRESS_B;
                            contact <= ENTRY_IS_LAST ? 1'b1 : lfsr_bit;
                        end else begin
                            state   <= HELD;
                            contact <= 1'b1;
                        end
                    end
                end
                PRESS_B, REL_B: begin
                    if (win_last) begin
                        if (state == PRESS_B) begin
                            state    <= HELD;
                            contact  <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            state   <= IDLE;
                            contact <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        win_cnt  <= win_cnt + 1'b1;
                        step_cnt <= step_due ? '0 : step_cnt + 1'b1;
                        if (next_last) begin
                            contact <= (state == PRESS_B);
                        end else if (step_due) begin
                            contact <= lfsr_bit;
                        end
                    end
                end
                HELD: begin
                    if (hold_last) begin
                        if (bounce_q) begin
                            state    <= REL_B;
                            win_cnt  <= '0;
                            step_cnt <= '0;
                            contact  <= ENTRY_IS_LAST ? 1'b0 : lfsr_bit;
                        end else begin
                            state   <= IDLE;
                            contact <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    contact <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        row_hit        = 4'b0000;
        row_hit[row_q] = contact & ~C[col_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            R <= 4'hF;
        end else begin
            R <= ~row_hit;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed bench for the single-key keypad emulator.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_keypad_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [23:0] cmd_hold;
    logic        cmd_bounce;
    logic [3:0]  C;
    logic [3:0]  R;
    logic        contact;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_bad = 0;

    // Hand-derived contact trace for key D, hold 8, bounce on, seed A5.
    bit c_exp [0:39] = '{
        0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1,
        1, 1, 1, 1, 1, 1, 1, 1,
        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0
    };

    logic [3:0] walk [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] trace [0:1][0:41];

    always #5 clk = ~clk;

    keypad_emulator dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_key    (cmd_key),
        .cmd_hold   (cmd_hold),
        .cmd_bounce (cmd_bounce),
        .C          (C),
        .R          (R),
        .contact    (contact),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] key, input logic [23:0] hold,
                         input logic bnc);
        cmd_key    = key;
        cmd_hold   = hold;
        cmd_bounce = bnc;
        cmd_valid  = 1'b1;
    endtask

    task automatic run_t3(input int p);
        int busy_n;
        logic [3:0] er;
        busy_n = 0;
        C = 4'b0111;
        issue(4'hD, 24'd8, 1'b1);
        for (int j = 1; j <= 41; j++) begin
            tick();
            if (j == 1) cmd_valid = 1'b0;
            er = 4'hF;
            if (j >= 2) er = {~c_exp[j-2], 3'b111};
            trace[p][j] = R;
            check($sformatf("t3.%0d R j=%0d", p, j), R, er);
            check($sformatf("t3.%0d contact j=%0d", p, j), contact,
                  (j <= 40) ? c_exp[j-1] : 1'b0);
            check($sformatf("t3.%0d done j=%0d", p, j), done, (j == 41));
            if (busy) busy_n++;
        end
        check($sformatf("t3.%0d busy cycles", p), busy_n, 40);
        tick();
        check($sformatf("t3.%0d done cleared", p), done, 1'b0);
    endtask

    task automatic run_t5(input string tag, input logic [3:0] cval,
                          input logic [3:0] rexp);
        C = cval;
        issue(4'h0, 24'd0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        check({tag, " contact on"}, contact, 1'b1);
        check({tag, " R before"}, R, 4'hF);
        tick();
        check({tag, " contact off"}, contact, 1'b0);
        check({tag, " done"}, done, 1'b1);
        check({tag, " R"}, R, rexp);
        tick();
        check({tag, " R after"}, R, 4'hF);
    endtask

    initial begin
        int r_low;
        int done_n;
        logic [3:0] er;

        // 1: reset with all columns driven
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_key    = 4'h0;
        cmd_hold   = 24'd0;
        cmd_bounce = 1'b0;
        C          = 4'b0000;
        tick(); tick(); tick();
        check("rst R", R, 4'hF);
        check("rst done", done, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst contact", contact, 1'b0);
        check("rst ready", cmd_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("post-rst ready", cmd_ready, 1'b1);

        // 2: key 5, hold 20, clean, scanner walking one column low
        C = walk[0];
        issue(4'h5, 24'd20, 1'b0);
        r_low  = 0;
        done_n = 0;
        for (int j = 1; j <= 23; j++) begin
            tick();
            if (j == 1) cmd_valid = 1'b0;
            er = 4'hF;
            if (j >= 2 && j <= 21 && walk[(j-1)%4] == 4'b1101) er = 4'b1101;
            check($sformatf("t2 R j=%0d", j), R, er);
            check($sformatf("t2 contact j=%0d", j), contact,
                  (j >= 1 && j <= 20));
            if (R == 4'b1101) r_low++;
            if (done) done_n++;
            C = walk[j%4];
        end
        check("t2 R low cycles", r_low, 5);
        check("t2 done pulses", done_n, 1);

        // 3: key D, hold 8, bounce on
        run_t3(0);

        // 4: second command held valid while key 9 is active
        C = 4'b1011;
        issue(4'h9, 24'd6, 1'b0);
        for (int j = 1; j <= 13; j++) begin
            tick();
            if (j == 1) begin
                cmd_key  = 4'h1;
                cmd_hold = 24'd3;
            end
            if (j == 9) cmd_valid = 1'b0;
            er = 4'hF;
            if (j >= 2 && j <= 7) er = 4'b1011;
            if (j >= 10 && j <= 12) er = 4'b1110;
            check($sformatf("t4 R j=%0d", j), R, er);
            check($sformatf("t4 contact j=%0d", j), contact,
                  (j <= 6) || (j >= 9 && j <= 11));
            check($sformatf("t4 busy j=%0d", j), busy,
                  (j <= 6) || (j >= 9 && j <= 11));
            check($sformatf("t4 done j=%0d", j), done, (j == 7 || j == 12));
            check($sformatf("t4 ready j=%0d", j), cmd_ready,
                  (j == 8 || j == 13));
            C = (j >= 9) ? 4'b1110 : 4'b1011;
        end

        // 5: key 0, hold 0 behaves as a single closed cycle
        run_t5("t5 col1 low", 4'b1101, 4'b0111);
        run_t5("t5 col1 high", 4'b1011, 4'hF);
        run_t5("t5 all low", 4'b0000, 4'b0111);

        // 6: reset in the middle of HELD, then replay test 3
        C = 4'b1101;
        issue(4'h5, 24'd20, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check("t6 held contact", contact, 1'b1);
        check("t6 held R", R, 4'b1101);
        reset = 1'b1;
        tick();
        check("t6 rst R", R, 4'hF);
        check("t6 rst contact", contact, 1'b0);
        check("t6 rst busy", busy, 1'b0);
        check("t6 rst done", done, 1'b0);
        check("t6 rst ready", cmd_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("t6 ready", cmd_ready, 1'b1);
        done_n = 0;
        for (int j = 0; j < 25; j++) begin
            tick();
            if (done) done_n++;
        end
        check("t6 no done", done_n, 0);
        run_t3(1);
        for (int j = 1; j <= 41; j++) begin
            check($sformatf("t6 replay j=%0d", j), trace[1][j], trace[0][j]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
